bwt_sort_ctrl: RTL and testbench
================================

Name: bwt_sort_ctrl

Overview:
- Pass sequencer for the 8-row BWT merge-sort core (start / sort_num / sorted interface). Runs one stable sort pass per key column, least-significant column first.
- Holds the rotation matrix in a local buffer between passes. Feeds each pass result back as the next pass input.
- Presents the fully sorted matrix to the host with a done pulse.
- Sits between the host/BWT front end and the sort core.

Parameters:
- COLUMN, 3: bytes per row and number of key passes; legal range 1..4 (sort_num is 2 bits).
- STRING_LEN, 8: rows per matrix; fixed to match the core.
- GAP_CYCLES, 4: idle cycles between passes so the core FIFOs drain; legal range 1..15.
- TIMEOUT, 255: maximum cycles from core_start to the sorted rising edge before an error is flagged.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start request; sampled only in IDLE or ERR.
- data_in  in  [7:0] x [0:STRING_LEN-1][COLUMN-1:0]  unsorted matrix; latched on an accepted go.
- data_out  out  [7:0] x [0:STRING_LEN-1][COLUMN-1:0]  sorted matrix; registered; held until the next done.
- busy  out  1  high from the cycle after an accepted go until the cycle done is asserted.
- done  out  1  one-cycle pulse when data_out is updated.
- error  out  1  sticky timeout flag.
- core_start  out  1  one-cycle start pulse to the sort core.
- core_sort_num  out  2  key column index for the current pass.
- core_data_in  out  same as data_in  driven continuously from the local buffer.
- core_data_out  in  same as data_in  sort core result.
- core_sorted  in  1  sort core completion level.

Behaviour:
- Reset values: state IDLE; busy, done, error, core_start all 0; core_sort_num 0; buffer 0; data_out 0; pass counter, gap counter and timer 0; sorted_q 0.
- rst mid-operation aborts immediately to these values. No done is issued.
- sorted_q <= core_sorted every cycle in every state. sorted_rise = core_sorted & ~sorted_q.
- IDLE:
  - go=1: buf <= data_in; pass <= COLUMN-1; busy <= 1; go to KICK.
  - go=0: remain in IDLE.
- KICK (1 cycle):
  - core_start=1, core_sort_num=pass, timer <= 0.
  - Go to WAIT.
- WAIT:
  - core_sort_num held; core_start=0; timer increments each cycle.
  - sorted_rise: go to SETTLE. Required because the core writes its last row one cycle after sorted rises.
  - Otherwise, when timer == TIMEOUT: go to ERR.
  - A stale core_sorted level held from the previous pass is not an edge and is ignored.
- SETTLE (1 cycle): buf <= core_data_out.
  - pass==0: go to FINISH.
  - Otherwise: pass <= pass-1; gap <= 0; go to GAP.
- GAP:
  - gap increments each cycle.
  - When gap == GAP_CYCLES-1: go to KICK.
- FINISH (1 cycle): data_out <= buf; done=1; busy <= 0; go to IDLE.
  - A go arriving in the same cycle is not accepted; it must be reasserted in IDLE.
- ERR:
  - error=1, busy=0, core_start=0.
  - go=1: error <= 0; latch data_in; behave as the IDLE accept.
- Pass count and latency:
  - Exactly COLUMN core_start pulses per job.
  - core_sort_num sequence is COLUMN-1 down to 0.
  - Job latency = 1 + COLUMN*(1 + W + 1) + (COLUMN-1)*GAP_CYCLES + 1, where W = WAIT cycles per pass.
- go while busy: ignored, no side effects.
- core_data_in changes only in IDLE-accept and SETTLE. It is stable from KICK through WAIT.

Test Plan:
- Reset: assert rst 2 cycles during WAIT → next cycle busy=0, done=0, error=0, core_start=0, core_sort_num=0, data_out all 0x00. No further core_start without go.
- Full job, COLUMN=3, behavioural core model (sorted rises 10 cycles after start, returns a stable sort on column sort_num):
  - Input rotations of "BANANA$\0".
  - Expect core_start pulses with core_sort_num 2,1,0.
  - done pulses once; data_out is the lexicographically sorted rotations; busy low in the done cycle.
- Feedback: core model returns a distinct marker matrix per pass (row r = {pass, r, 0xA5}) → next pass core_data_in equals the marker captured one cycle after the sorted rise. Final data_out equals the pass-0 marker.
- go held high throughout the job → exactly one job executes, 3 starts, 1 done; second job begins only after go is seen in IDLE.
- Timeout, TIMEOUT=20: core never raises sorted → error=1 exactly 21 cycles after the KICK cycle; busy=0; no done. Next go clears error and the job completes normally.
- Stale level: core holds sorted=1 across GAP into the next pass, drops it, then re-raises it after 5 cycles → controller leaves WAIT only on the re-rise, 5 cycles in.

Source files
------------

// File: rtl/bwt_sort_ctrl.sv
// Pass sequencer for the 8-row BWT merge-sort core: one stable sort pass per key column,
// least-significant column first, each pass result fed back as the next pass input.
module bwt_sort_ctrl #(
   parameter int unsigned COLUMN     = 3,
   parameter int unsigned STRING_LEN = 8,
   parameter int unsigned GAP_CYCLES = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   go,
   input  logic [0:STRING_LEN-1][COLUMN-1:0][7:0] data_in,
   output logic [0:STRING_LEN-1][COLUMN-1:0][7:0] data_out,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   error,
   output logic                                   core_start,
   output logic [1:0]                             core_sort_num,
   output logic [0:STRING_LEN-1][COLUMN-1:0][7:0] core_data_in,
   input  logic [0:STRING_LEN-1][COLUMN-1:0][7:0] core_data_out,
   input  logic                                   core_sorted
);

   localparam int unsigned PASS_W = 2;
   localparam int unsigned GAP_W  = 4;
   localparam int unsigned TMR_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_KICK,
      S_WAIT,
      S_SETTLE,
      S_GAP,
      S_FINISH,
      S_ERR
   } state_e;

   state_e                                   state_q, state_d;
   logic [0:STRING_LEN-1][COLUMN-1:0][7:0]   buf_q, buf_d;
   logic [0:STRING_LEN-1][COLUMN-1:0][7:0]   data_out_q, data_out_d;
   logic [PASS_W-1:0]                        pass_q, pass_d;
   logic [GAP_W-1:0]                         gap_q, gap_d;
   logic [TMR_W-1:0]                         timer_q, timer_d;
   logic                                     busy_q, busy_d;
   logic                                     done_q, done_d;
   logic                                     error_q, error_d;
   logic                                     core_start_q, core_start_d;
   logic [1:0]                               core_sort_num_q, core_sort_num_d;
   logic                                     sorted_q;
   logic                                     sorted_rise;

   // Only a fresh edge ends a pass; a level left over from the previous pass does not.
   assign sorted_rise = core_sorted & ~sorted_q;

   always_comb begin
      state_d         = state_q;
      buf_d           = buf_q;
      data_out_d      = data_out_q;
      pass_d          = pass_q;
      gap_d           = gap_q;
      timer_d         = timer_q;
      busy_d          = busy_q;
      done_d          = 1'b0;
      error_d         = error_q;
      core_start_d    = 1'b0;
      core_sort_num_d = core_sort_num_q;

      case (state_q)
         S_IDLE, S_ERR: begin
            if (go) begin
               buf_d   = data_in;
               pass_d  = PASS_W'(COLUMN - 1);
               busy_d  = 1'b1;
               error_d = 1'b0;
               state_d = S_KICK;
            end
         end
         S_KICK: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_q + TMR_W'(1);
            if (sorted_rise) begin
               state_d = S_SETTLE;
            end else if (timer_d == TMR_W'(TIMEOUT)) begin
               busy_d  = 1'b0;
               error_d = 1'b1;
               state_d = S_ERR;
            end
         end
         // The core writes its last row one cycle after sorted rises, so capture here.
         S_SETTLE: begin
            buf_d = core_data_out;
            if (pass_q == '0) begin
               state_d = S_FINISH;
            end else begin
               pass_d  = pass_q - PASS_W'(1);
               gap_d   = '0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            gap_d = gap_q + GAP_W'(1);
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
               state_d = S_KICK;
            end
         end
         S_FINISH: begin
            data_out_d = buf_q;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Start strobe and key index are registered so they appear during the KICK cycle.
      if (state_d == S_KICK) begin
         core_start_d    = 1'b1;
         core_sort_num_d = pass_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         buf_q           <= '0;
         data_out_q      <= '0;
         pass_q          <= '0;
         gap_q           <= '0;
         timer_q         <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
         core_start_q    <= 1'b0;
         core_sort_num_q <= '0;
         sorted_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         buf_q           <= buf_d;
         data_out_q      <= data_out_d;
         pass_q          <= pass_d;
         gap_q           <= gap_d;
         timer_q         <= timer_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         error_q         <= error_d;
         core_start_q    <= core_start_d;
         core_sort_num_q <= core_sort_num_d;
         sorted_q        <= core_sorted;
      end
   end

   assign data_out      = data_out_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign core_start    = core_start_q;
   assign core_sort_num = core_sort_num_q;
   assign core_data_in  = buf_q;

endmodule

// File: tb/tb_bwt_sort_ctrl.sv
// Directed bench for bwt_sort_ctrl with a behavioural sort-core model (COLUMN=3, TIMEOUT=20).
module tb_bwt_sort_ctrl;

   typedef logic [0:7][2:0][7:0] matrix_t;

   logic    clk = 1'b0;
   logic    rst = 1'b1;
   logic    go = 1'b0;
   matrix_t data_in = '0;
   matrix_t data_out;
   logic    busy, done, error, core_start;
   logic [1:0] core_sort_num;
   matrix_t core_data_in;
   matrix_t core_data_out = '0;
   logic    core_sorted = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bwt_sort_ctrl #(
      .COLUMN(3), .STRING_LEN(8), .GAP_CYCLES(4), .TIMEOUT(20)
   ) dut (
      .clk(clk), .rst(rst), .go(go), .data_in(data_in), .data_out(data_out),
      .busy(busy), .done(done), .error(error), .core_start(core_start),
      .core_sort_num(core_sort_num), .core_data_in(core_data_in),
      .core_data_out(core_data_out), .core_sorted(core_sorted)
   );

   function automatic logic [2:0][7:0] row3(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2);
      return {b2, b1, b0};
   endfunction

   function automatic matrix_t marker(input int p);
      matrix_t m;
      for (int r = 0; r < 8; r++) m[r] = {8'(p), 8'(r), 8'hA5};
      return m;
   endfunction

   // Stable counting sort on one byte column, as the real core would do.
   function automatic matrix_t sort_col(input matrix_t m, input int col);
      matrix_t res;
      int n;
      res = '0;
      n = 0;
      for (int v = 0; v < 256; v++)
         for (int i = 0; i < 8; i++)
            if (m[i][col] == 8'(v)) begin
               res[n] = m[i];
               n++;
            end
      return res;
   endfunction

   // Core model: knobs select when sorted drops/rises (cycles after the start cycle).
   int cnt = 0;
   int drop_at = 1;
   int rise_at = 10;
   bit never = 1'b0;
   bit marker_mode = 1'b0;
   matrix_t src = '0;
   logic [1:0] snum = '0;

   always @(posedge clk) begin : core_model
      int c;
      c = core_start ? 1 : ((cnt == 0) ? 0 : ((cnt < 1000) ? cnt + 1 : cnt));
      cnt <= c;
      if (core_start) begin
         src  <= core_data_in;
         snum <= core_sort_num;
      end
      if (c >= drop_at && c > 0) core_sorted <= !never && (c >= rise_at);
      if (!never && c == rise_at + 1)
         core_data_out <= marker_mode ? marker(int'(snum)) : sort_col(src, int'(snum));
   end

   matrix_t banana, sorted_exp, junk;

   // Observations collected by run_job; k counts negedges after go is raised.
   int n_starts, n_done, done_k, err_k;
   int st_k[8];
   logic [1:0] sn[8];
   matrix_t kdin[8];
   matrix_t dout;
   logic busy_done, busy_err, busy_k1;

   task automatic run_job(input matrix_t m, input bit hold, input int ncyc);
      n_starts = 0; n_done = 0; done_k = 0; err_k = 0;
      busy_done = 1'bx; busy_err = 1'bx; busy_k1 = 1'bx; dout = '0;
      @(negedge clk);
      go = 1'b1;
      data_in = m;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (k == 1) busy_k1 = busy;
         if (core_start && n_starts < 8) begin
            st_k[n_starts] = k;
            sn[n_starts]   = core_sort_num;
            kdin[n_starts] = core_data_in;
            n_starts++;
         end
         if (done) begin
            if (n_done == 0) begin
               done_k = k;
               dout = data_out;
               busy_done = busy;
            end
            n_done++;
         end
         if (error && err_k == 0) begin
            err_k = k;
            busy_err = busy;
         end
         if (k == 1 && !hold) go = 1'b0;
         if (hold) data_in = junk;
      end
      go = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b expected 0", error); end
      checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b expected 0", core_start); end
      checks++; if (data_out !== '0) begin errors++; $display("FAIL rst_dout: got %h expected 0", data_out); end
   endtask

   task automatic test_full_job;
      run_job(banana, 1'b0, 55);
      checks++; if (busy_k1 !== 1'b1) begin errors++; $display("FAIL full_busy_k1: got %b expected 1", busy_k1); end
      checks++; if (n_starts !== 3) begin errors++; $display("FAIL full_starts: got %0d expected 3", n_starts); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (sn[i] !== 2'(2 - i)) begin
            errors++; $display("FAIL full_sort_num%0d: got %0d expected %0d", i, sn[i], 2 - i);
         end
      end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL full_ndone: got %0d expected 1", n_done); end
      checks++; if (done_k !== 46) begin errors++; $display("FAIL full_latency: got %0d expected 46", done_k); end
      checks++; if (dout !== sorted_exp) begin errors++; $display("FAIL full_dout: got %h expected %h", dout, sorted_exp); end
      checks++; if (busy_done !== 1'b0) begin errors++; $display("FAIL full_busy_done: got %b expected 0", busy_done); end
   endtask

   task automatic test_feedback;
      marker_mode = 1'b1;
      run_job(banana, 1'b0, 55);
      marker_mode = 1'b0;
      checks++; if (kdin[0] !== banana) begin errors++; $display("FAIL fb_pass0_in: got %h expected %h", kdin[0], banana); end
      checks++; if (kdin[1] !== marker(2)) begin errors++; $display("FAIL fb_pass1_in: got %h expected %h", kdin[1], marker(2)); end
      checks++; if (kdin[2] !== marker(1)) begin errors++; $display("FAIL fb_pass2_in: got %h expected %h", kdin[2], marker(1)); end
      checks++; if (dout !== marker(0)) begin errors++; $display("FAIL fb_dout: got %h expected %h", dout, marker(0)); end
   endtask

   task automatic test_go_held;
      int exp_k[4];
      exp_k = '{1, 17, 33, 47};
      run_job(banana, 1'b1, 52);
      checks++; if (n_starts !== 4) begin errors++; $display("FAIL held_starts: got %0d expected 4", n_starts); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (st_k[i] !== exp_k[i]) begin
            errors++; $display("FAIL held_start_cycle%0d: got %0d expected %0d", i, st_k[i], exp_k[i]);
         end
      end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL held_ndone: got %0d expected 1", n_done); end
      checks++; if (done_k !== 46) begin errors++; $display("FAIL held_latency: got %0d expected 46", done_k); end
      checks++; if (dout !== sorted_exp) begin errors++; $display("FAIL held_dout: got %h expected %h", dout, sorted_exp); end
   endtask

   task automatic test_reset_mid;
      int starts, dones;
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
      checks++; if (core_sort_num !== 2'd0) begin errors++; $display("FAIL mid_sort_num: got %0d expected 0", core_sort_num); end
      checks++; if (data_out !== '0) begin errors++; $display("FAIL mid_dout: got %h expected 0", data_out); end
      checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL mid_start: got %b expected 0", core_start); end
      starts = 0; dones = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (core_start) starts++;
         if (done) dones++;
      end
      checks++; if (starts !== 0) begin errors++; $display("FAIL mid_idle_starts: got %0d expected 0", starts); end
      checks++; if (dones !== 0) begin errors++; $display("FAIL mid_idle_dones: got %0d expected 0", dones); end
   endtask

   task automatic test_timeout;
      never = 1'b1;
      run_job(banana, 1'b0, 35);
      never = 1'b0;
      checks++; if (err_k !== 22) begin errors++; $display("FAIL to_error_cycle: got %0d expected 22", err_k); end
      checks++; if (busy_err !== 1'b0) begin errors++; $display("FAIL to_busy: got %b expected 0", busy_err); end
      checks++; if (n_done !== 0) begin errors++; $display("FAIL to_ndone: got %0d expected 0", n_done); end
      checks++; if (n_starts !== 1) begin errors++; $display("FAIL to_starts: got %0d expected 1", n_starts); end
      run_job(banana, 1'b0, 50);
      checks++; if (err_k !== 0) begin errors++; $display("FAIL to_clear: got error at %0d expected none", err_k); end
      checks++; if (done_k !== 46) begin errors++; $display("FAIL to_recover_latency: got %0d expected 46", done_k); end
      checks++; if (dout !== sorted_exp) begin errors++; $display("FAIL to_recover_dout: got %h expected %h", dout, sorted_exp); end
   endtask

   task automatic test_stale;
      drop_at = 3;
      rise_at = 8;
      run_job(banana, 1'b0, 50);
      drop_at = 1;
      rise_at = 10;
      checks++; if (st_k[1] !== 15) begin errors++; $display("FAIL stale_start1: got %0d expected 15", st_k[1]); end
      checks++; if (st_k[2] !== 29) begin errors++; $display("FAIL stale_start2: got %0d expected 29", st_k[2]); end
      checks++; if (done_k !== 40) begin errors++; $display("FAIL stale_latency: got %0d expected 40", done_k); end
      checks++; if (dout !== sorted_exp) begin errors++; $display("FAIL stale_dout: got %h expected %h", dout, sorted_exp); end
   endtask

   initial begin
      banana[0] = row3("B", "A", "N");
      banana[1] = row3("A", "N", "A");
      banana[2] = row3("N", "A", "N");
      banana[3] = row3("A", "N", "A");
      banana[4] = row3("N", "A", "$");
      banana[5] = row3("A", "$", 8'h00);
      banana[6] = row3("$", 8'h00, "B");
      banana[7] = row3(8'h00, "B", "A");
      sorted_exp[0] = row3(8'h00, "B", "A");
      sorted_exp[1] = row3("$", 8'h00, "B");
      sorted_exp[2] = row3("A", "$", 8'h00);
      sorted_exp[3] = row3("A", "N", "A");
      sorted_exp[4] = row3("A", "N", "A");
      sorted_exp[5] = row3("B", "A", "N");
      sorted_exp[6] = row3("N", "A", "$");
      sorted_exp[7] = row3("N", "A", "N");
      for (int r = 0; r < 8; r++) junk[r] = {8'h5A, 8'(r), 8'hC3};

      test_reset();
      test_full_job();
      test_feedback();
      test_go_held();
      test_reset_mid();
      test_timeout();
      test_stale();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
